// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation encodings,
// FSM state type and the iteration-counter sizing helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // The counter has to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit.sv
// Iterative MIPS-style HI/LO unit: one bit per cycle multiply (shift-add) and
// restoring divide, sharing a single WIDTH+1-bit adder/subtractor.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dbz
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  op_e                op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, opnd_q, a_q;
  logic               neg_q, neg_rem_q, done_q, dbz_q;

  op_e                op_in;
  logic               accept, signed_op, a_neg, b_neg, is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_x, add_y;
  logic               add_sub, no_borrow;
  logic [WIDTH+1:0]   add_sum;
  logic [2*WIDTH-1:0] prod, sprod, fix_hilo;
  logic               fix_dbz;

  assign op_in     = op_e'(op);
  assign accept    = (state_q == IDLE) && start && !cancel;
  assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV) ||
                     (op_in == OP_MADD) || (op_in == OP_MSUB);
  assign a_neg     = signed_op && a[WIDTH-1];
  assign b_neg     = signed_op && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply adds the multiplicand into the high half when the next multiplier
  // bit is set; divide trial-subtracts the divisor from the shifted remainder.
  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign add_sub   = is_div;
  assign add_x     = is_div ? {acc_hi_q, acc_lo_q[WIDTH-1]} : {1'b0, acc_hi_q};
  assign add_y     = (is_div || acc_lo_q[0]) ? {1'b0, opnd_q} : '0;
  assign add_sum   = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)} +
                     {{(WIDTH+1){1'b0}}, add_sub};
  assign no_borrow = add_sum[WIDTH+1];

  assign prod  = {acc_hi_q, acc_lo_q};
  assign sprod = neg_q ? -prod : prod;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the case statement can leave it holding state (a latch).
  always_comb begin
    fix_hilo = {hi_q, lo_q};
    fix_dbz  = 1'b0;
    case (op_q)
      OP_MULT, OP_MULTU: fix_hilo = sprod;
      OP_MADD:           fix_hilo = {hi_q, lo_q} + sprod;
      OP_MSUB:           fix_hilo = {hi_q, lo_q} - sprod;
      OP_DIV, OP_DIVU: begin
        if (opnd_q == '0) begin
          fix_hilo = {a_q, {WIDTH{1'b1}}};
          fix_dbz  = 1'b1;
        end else begin
          fix_hilo = {(neg_rem_q ? -acc_hi_q : acc_hi_q),
                      (neg_q ? -acc_lo_q : acc_lo_q)};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && op_in != OP_MTHI && op_in != OP_MTLO) state_d = CALC;
      CALC: begin
        if (cancel)                   state_d = IDLE;
        else if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op_in == OP_MTHI) begin
              hi_q <= a;
            end else if (op_in == OP_MTLO) begin
              lo_q <= a;
            end else begin
              // Multiplier / dividend magnitude sits in the low half and shifts out.
              op_q      <= op_in;
              cnt_q     <= CNT_W'(WIDTH);
              acc_hi_q  <= '0;
              acc_lo_q  <= b_mag;
              opnd_q    <= a_mag;
              a_q       <= a;
              neg_q     <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              if (op_in == OP_DIV || op_in == OP_DIVU) begin
                acc_lo_q <= a_mag;
                opnd_q   <= b_mag;
              end
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (is_div) begin
            acc_hi_q <= no_borrow ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], no_borrow};
          end else begin
            acc_hi_q <= add_sum[WIDTH:1];
            acc_lo_q <= {add_sum[0], acc_lo_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!cancel) begin
            hi_q   <= fix_hilo[2*WIDTH-1:WIDTH];
            lo_q   <= fix_hilo[WIDTH-1:0];
            done_q <= 1'b1;
            dbz_q  <= fix_dbz;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy && (start || rd_req);
  assign done  = done_q;
  assign dbz   = dbz_q;

endmodule

// File: doc/muldiv_hilo_unit.md
MULDIV_HILO_UNIT -- requirements
Module: muldiv_hilo_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width, any even value 8..64.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to execute op.
REQ-005 SHALL have port op, input, 3 bits: MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI, MTLO.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: rs and rt operands; MTHI/MTLO use a only.
REQ-007 SHALL have port cancel, input, 1 bit: abort the in-flight operation (branch flush).
REQ-008 SHALL have port rd_req, input, 1 bit: an MFHI/MFLO is in decode.
REQ-009 SHALL have ports hi and lo, output, WIDTH bits each: architectural HI/LO registers.
REQ-010 SHALL have port busy, output, 1 bit: iterative operation in progress.
REQ-011 SHALL have port stall, output, 1 bit: combinational, busy & (start | rd_req); holds the pipeline.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO update from MULT/DIV/MADD/MSUB.
REQ-013 SHALL have port dbz, output, 1 bit: one-cycle pulse, coincident with done, for DIV/DIVU with b=0.

Function
REQ-014 SHALL use FSM states IDLE, CALC, FIX; start is accepted only in IDLE with cancel=0.
REQ-015 SHALL handle accepted MTHI/MTLO as follows: write a into hi/lo at the accepting edge; stay in IDLE; no done pulse.
REQ-016 SHALL handle accepted iterative ops as follows: latch operands and magnitudes at edge k; CALC for WIDTH edges, 1 bit per edge (shift-add / restoring shift-subtract); FIX one edge (sign correction, accumulate); hi/lo and done at edge k+WIDTH+1.
REQ-017 SHALL assert busy from edge k until edge k+WIDTH+1, then deassert it.
REQ-018 SHALL compute MULT/MULTU as {hi,lo} = the 2*WIDTH-bit product of a and b, signed or unsigned respectively.
REQ-019 SHALL compute MADD/MSUB as {hi,lo} +/- signed product, modulo 2^(2*WIDTH).
REQ-020 SHALL compute DIV/DIVU as lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
REQ-021 SHALL, on divide by zero, set hi = a and lo = all ones, and pulse dbz.
REQ-022 SHALL, for DIV of MIN by -1, set lo = MIN, hi = 0, with no flag.
REQ-023 SHALL ignore start while busy; stall stays high so the requester repeats the request after done.
REQ-024 SHALL, on cancel in CALC or FIX, return to IDLE next edge with hi/lo unchanged and no done; cancel in IDLE is a no-op.
REQ-025 SHALL give cancel priority over completion when cancel and the final FIX edge coincide.
REQ-026 SHALL, when start and cancel are asserted together in IDLE, reject the request.
REQ-027 SHALL drive hi/lo directly from registers; a read in the done cycle sees the new values.

Reset
REQ-028 SHALL, on Rst low, immediately force state IDLE; hi, lo and all internal registers to 0; busy, done and dbz to 0.
REQ-029 SHALL, on reset mid-operation, discard the operation with no done.
REQ-030 SHALL resume accepting start on the first rising edge after Rst deasserts.

Structure
REQ-031 SHALL place the op encodings, the FSM state type and the iteration-counter width ($clog2(WIDTH+1)) in shared package muldiv_pkg.
REQ-032 SHALL be a single module with no sub-module; one shared WIDTH+1-bit adder/subtractor serves both multiply and divide.

Verification (WIDTH=32)
REQ-033 SHALL cover: MULT a=0xFFFFFFFF, b=2 -> done at k+33; hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi=7, lo=0xFFFFFFFF, dbz pulse coincident with done.
REQ-035 SHALL cover: MTLO 5, then MADD a=3, b=4 -> hi=0, lo=17; then MSUB a=3, b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
REQ-036 SHALL cover: start DIV, then assert start and rd_req at k+5 -> stall high until done, no second acceptance, result unaffected.
REQ-037 SHALL cover: cancel at k+10 of MULT (and separately at the FIX edge) -> IDLE next edge, hi/lo hold prior values, no done.
REQ-038 SHALL cover: Rst low at k+20 of DIV -> hi=lo=0, busy=0 asynchronously; a new MULT 6*7 after release -> lo=42.
